// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared state encodings and mux select values for the memory port arbiter
package mem_port_arbiter_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY_A = 2'b01,
    BUSY_B = 2'b10
  } state_t;
  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;
endpackage

// File: rtl/mem_bus_mux2.sv
// mem_bus_mux2: W-bit 2:1 mux built per bit from NAND-form select logic
module mem_bus_mux2 #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         s,
  output logic [W-1:0] y
);
  for (genvar i = 0; i < W; i++) begin : g_bit
    assign y[i] = ~(~(a[i] & ~s) & ~(b[i] & s));
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter sharing one memory port between requesters A and B with timeout abort
module mem_port_arbiter #(
  parameter int AW = 16,
  parameter int DW = 16,
  parameter int TIMEOUT = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_a,
  input  logic [AW-1:0] addr_a,
  input  logic          wr_a,
  input  logic [DW-1:0] wdata_a,
  input  logic          req_b,
  input  logic [AW-1:0] addr_b,
  input  logic          wr_b,
  input  logic [DW-1:0] wdata_b,
  input  logic          mem_done,
  output logic          mem_en,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wr,
  output logic [DW-1:0] mem_wdata,
  output logic          sel,
  output logic          gnt_a,
  output logic          gnt_b,
  output logic          ack_a,
  output logic          ack_b,
  output logic          err
);
  import mem_port_arbiter_pkg::*;
  localparam int CW = $clog2(TIMEOUT);
  state_t state, nxt;
  logic last, idle, go_a, go_b, timeout, ack, bus_wr;
  logic [CW-1:0] cnt;
  always_comb begin
    gnt_a = state == BUSY_A;
    gnt_b = state == BUSY_B;
    idle = ~(gnt_a | gnt_b);
    mem_en = ~idle;
    timeout = cnt == CW'(TIMEOUT - 1);
    ack_a = gnt_a & (mem_done | timeout);
    ack_b = gnt_b & (mem_done | timeout);
    ack = ack_a | ack_b;
    err = ack & ~mem_done;
    go_a = idle & req_a & (~req_b | last);
    go_b = idle & req_b & ~go_a;
    nxt = go_a ? BUSY_A : go_b ? BUSY_B : (ack | idle) ? IDLE : state;
    mem_wr = bus_wr & mem_en;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sel <= SEL_A;
      last <= SEL_B;
      cnt <= '0;
    end else begin
      state <= nxt;
      if (go_a | go_b) sel <= go_b ? SEL_B : SEL_A;
      if (ack) last <= ack_b ? SEL_B : SEL_A;
      cnt <= (ack | idle) ? '0 : cnt + 1'b1;
    end
  end
  mem_bus_mux2 #(.W(AW + 1 + DW)) u_mux (
    .a({addr_a, wr_a, wdata_a}),
    .b({addr_b, wr_b, wdata_b}),
    .s(sel),
    .y({mem_addr, bus_wr, mem_wdata})
  );
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized checks of mem_port_arbiter against a transaction-level model
module tb_mem_port_arbiter;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int TIMEOUT = 8;
  logic clk = 0;
  logic rst, req_a, wr_a, req_b, wr_b, mem_done;
  logic [AW-1:0] addr_a, addr_b, mem_addr;
  logic [DW-1:0] wdata_a, wdata_b, mem_wdata;
  logic mem_en, mem_wr, sel, gnt_a, gnt_b, ack_a, ack_b, err;
  int checks = 0;
  int failures = 0;
  int own = 0;
  int nb = 0;
  logic mlast = 1;
  logic msel = 0;
  logic started = 0;
  int exp_own [9] = '{2, 2, 0, 1, 1, 0, 2, 2, 0};
  always #5 clk = ~clk;
  mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .addr_a(addr_a), .wr_a(wr_a), .wdata_a(wdata_a),
    .req_b(req_b), .addr_b(addr_b), .wr_b(wr_b), .wdata_b(wdata_b),
    .mem_done(mem_done), .mem_en(mem_en), .mem_addr(mem_addr), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .sel(sel), .gnt_a(gnt_a), .gnt_b(gnt_b),
    .ack_a(ack_a), .ack_b(ack_b), .err(err)
  );
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", n, a, e, $time);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic look();
    #2;
  endtask
  // own: 0 idle, 1 A busy, 2 B busy; nb is the 1-based busy cycle number
  always @(posedge clk) begin
    started <= 1;
    if (rst) begin
      own <= 0; nb <= 0; mlast <= 1; msel <= 0;
    end else if (own == 0) begin
      if (req_a && (!req_b || mlast)) begin own <= 1; msel <= 0; nb <= 1; end
      else if (req_b) begin own <= 2; msel <= 1; nb <= 1; end
    end else if (mem_done || nb == TIMEOUT) begin
      own <= 0; nb <= 0; mlast <= (own == 2);
    end else nb <= nb + 1;
  end
  always @(negedge clk) begin
    if (started) begin
      logic en, sb, ea, eb;
      en = own != 0;
      sb = en ? (own == 2) : msel;
      ea = own == 1 && (mem_done || nb == TIMEOUT);
      eb = own == 2 && (mem_done || nb == TIMEOUT);
      chk("m_mem_en", 32'(mem_en), 32'(en));
      chk("m_gnt_a", 32'(gnt_a), 32'(own == 1));
      chk("m_gnt_b", 32'(gnt_b), 32'(own == 2));
      chk("m_sel", 32'(sel), 32'(msel));
      chk("m_addr", 32'(mem_addr), 32'(sb ? addr_b : addr_a));
      chk("m_wdata", 32'(mem_wdata), 32'(sb ? wdata_b : wdata_a));
      chk("m_wr", 32'(mem_wr), 32'(en & (sb ? wr_b : wr_a)));
      chk("m_ack_a", 32'(ack_a), 32'(ea));
      chk("m_ack_b", 32'(ack_b), 32'(eb));
      chk("m_err", 32'(err), 32'((ea | eb) & ~mem_done));
    end
  end
  initial begin
    rst = 1; req_a = 0; req_b = 0; wr_a = 0; wr_b = 0; mem_done = 0;
    addr_a = 0; addr_b = 0; wdata_a = 16'h1234; wdata_b = 16'hBEEF;
    step(); step();
    rst = 0;
    look();
    chk("rst_en", 32'(mem_en), 0);
    chk("rst_gnt", 32'({gnt_a, gnt_b}), 0);
    chk("rst_sel", 32'(sel), 0);
    chk("rst_ack", 32'({ack_a, ack_b, err}), 0);
    req_a = 1; addr_a = 16'h0040;
    look();
    chk("t1_no_gnt_yet", 32'(gnt_a), 0);
    step(); look();
    chk("t1_gnt_a", 32'(gnt_a), 1);
    chk("t1_en", 32'(mem_en), 1);
    chk("t1_addr", 32'(mem_addr), 32'h0040);
    chk("t1_sel", 32'(sel), 0);
    step();
    step(); mem_done = 1; look();
    chk("t1_ack_a", 32'(ack_a), 1);
    chk("t1_err", 32'(err), 0);
    step(); mem_done = 0; req_a = 0; look();
    chk("t1_idle", 32'({gnt_a, mem_en, ack_a}), 0);
    step(); req_a = 1; req_b = 1;
    for (int k = 1; k <= 9; k++) begin
      step();
      mem_done = (k % 3 == 2);
      if (k == 9) begin req_a = 0; req_b = 0; end
      look();
      chk($sformatf("t2_owner%0d", k), gnt_a ? 1 : gnt_b ? 2 : 0, exp_own[k-1]);
      if (exp_own[k-1] == 2) chk("t2_wdata_b", 32'(mem_wdata), 32'hBEEF);
      if (exp_own[k-1] == 1) chk("t2_wdata_a", 32'(mem_wdata), 32'h1234);
    end
    step(); mem_done = 0; req_b = 1; wr_b = 1; addr_b = 16'h0100; wdata_b = 16'h5A5A;
    for (int n = 1; n <= TIMEOUT; n++) begin
      step(); look();
      chk($sformatf("t3_ack_b%0d", n), 32'(ack_b), 32'(n == TIMEOUT));
      if (n == TIMEOUT) begin
        chk("t3_err", 32'(err), 1);
        chk("t3_wr", 32'(mem_wr), 1);
      end
    end
    step(); req_a = 1; req_b = 1; wr_b = 0; look();
    chk("t3_en_drop", 32'(mem_en), 0);
    step(); req_b = 0; look();
    chk("t3_then_a", 32'({gnt_a, gnt_b}), 32'b10);
    for (int n = 2; n <= TIMEOUT; n++) begin
      step(); mem_done = (n == TIMEOUT); look();
      if (n == TIMEOUT) begin
        chk("t4_ack_a", 32'(ack_a), 1);
        chk("t4_err", 32'(err), 0);
      end
    end
    step(); mem_done = 0; req_a = 0; look();
    chk("t4_idle", 32'(mem_en), 0);
    step(); req_a = 1;
    step(); req_a = 0; look();
    chk("t5_gnt_a", 32'(gnt_a), 1);
    step();
    step(); mem_done = 1; look();
    chk("t5_ack_a", 32'(ack_a), 1);
    step(); look();
    chk("t5_idle_done", 32'({ack_a, ack_b, mem_en}), 0);
    step(); mem_done = 0; req_b = 1;
    step();
    step(); rst = 1; look();
    chk("t6_gnt_b", 32'(gnt_b), 1);
    step(); rst = 0; req_a = 1; look();
    chk("t6_rst_out", 32'({mem_en, gnt_a, gnt_b, ack_a, ack_b, err, sel, mem_wr}), 0);
    step(); req_b = 0; mem_done = 1; look();
    chk("t6_then_a", 32'({gnt_a, gnt_b, ack_a}), 32'b101);
    step(); mem_done = 0; req_a = 0;
    for (int c = 0; c < 800; c++) begin
      step();
      rst = ($urandom_range(99) == 0);
      req_a = ($urandom_range(3) != 0);
      req_b = ($urandom_range(3) != 0);
      wr_a = 1'($urandom); wr_b = 1'($urandom);
      addr_a = 16'($urandom); addr_b = 16'($urandom);
      wdata_a = 16'($urandom); wdata_b = 16'($urandom);
      mem_done = ($urandom_range(4) == 0);
    end
    step(); step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported memory between two requesters: A (instruction fetch) and B (data access).
- Round-robin arbitration; the grant is held until the memory signals completion or a timeout expires.
- Drives the select of an internal 2:1 bus mux that steers the winner's address, write flag and write data onto the memory port.
- Sits between fetch/memory stages and the memory model in the unpipelined processor.

Parameters:
- AW, 16, address width.
- DW, 16, write-data width.
- TIMEOUT, 8, max cycles in a busy state before forced abort (>=2).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- req_a  in  1  requester A wants access.
- addr_a  in  AW  A address.
- wr_a  in  1  A write enable.
- wdata_a  in  DW  A write data.
- req_b  in  1  requester B wants access.
- addr_b  in  AW  B address.
- wr_b  in  1  B write enable.
- wdata_b  in  DW  B write data.
- mem_done  in  1  memory completes the current access this cycle.
- mem_en  out  1  memory access valid.
- mem_addr  out  AW  muxed address.
- mem_wr  out  1  muxed write enable.
- mem_wdata  out  DW  muxed write data.
- sel  out  1  mux select (0=A, 1=B), registered.
- gnt_a  out  1  A owns the port.
- gnt_b  out  1  B owns the port.
- ack_a  out  1  one-cycle completion pulse to A.
- ack_b  out  1  one-cycle completion pulse to B.
- err  out  1  qualifies ack: access aborted by timeout.

Behaviour:
- One clock (clk); synchronous, active-high reset (rst). All state updates on the rising edge of clk.
- States: IDLE, BUSY_A, BUSY_B. Registers: state, sel, last (last granted: 0=A, 1=B), cnt (timeout counter, width clog2(TIMEOUT)).
- Reset values:
  - state=IDLE, sel=0, last=1 (A wins the first tie), cnt=0.
  - Outputs: mem_en=0, gnt_a=0, gnt_b=0, ack_a=0, ack_b=0, err=0.
  - mem_addr/mem_wr/mem_wdata follow A (sel=0), but mem_wr is gated to 0 while mem_en=0.
- IDLE:
  - req_a only -> BUSY_A, sel<=0.
  - req_b only -> BUSY_B, sel<=1.
  - Both -> the requester not equal to last; sel set accordingly.
  - Neither -> stay.
  - Grant latency: req sampled at edge N; gnt_x and mem_en high from cycle N+1.
- BUSY_x:
  - mem_en=1, gnt_x=1.
  - mem_* outputs are combinational mux outputs of the granted requester's inputs.
  - cnt increments each cycle.
- Completion: ack_x = BUSY_x & (mem_done | cnt==TIMEOUT-1), combinational.
  - err = ack & ~mem_done.
  - mem_done and timeout in the same cycle -> err=0 (done wins).
  - Next edge: state<=IDLE, last<=x, cnt<=0.
- Mandatory single IDLE bubble between transactions. Back-to-back requests alternate A,B,A,B when both are held high.
- Requester contract: hold req/addr/wr/wdata stable from req until ack, and drop req the cycle after ack. A requester holding req after ack is treated as a new request.
- req_x deasserted mid-transaction: ignored; the access runs to done or timeout and ack still pulses.
- mem_done in IDLE: ignored, no ack.
- rst asserted mid-transaction: next edge returns to reset values; no ack is issued for the aborted access.
- TIMEOUT boundary: with no done, ack/err appear in the TIMEOUT-th busy cycle (cnt counts 0..TIMEOUT-1).

Decomposition:
- Shared package/include:
  - state encodings (IDLE=2'b00, BUSY_A=2'b01, BUSY_B=2'b10);
  - SEL_A=1'b0, SEL_B=1'b1.
- Sub-module mem_bus_mux2: an N-bit 2:1 mux (parameter W) built per bit from NAND-form select logic. Instantiate it for the address+wr+wdata bundle (width AW+1+DW).
- The FSM and counter stay in the top module.

Test Plan:
- Reset, then req_a=1, addr_a=16'h0040, wr_a=0; mem_done high in the 3rd busy cycle:
  - gnt_a and mem_en rise 1 cycle after req;
  - mem_addr=16'h0040, sel=0;
  - ack_a one cycle with err=0, then IDLE.
- req_a and req_b both held high from reset, mem_done asserted every 2nd busy cycle:
  - grants alternate A,B,A,B with one IDLE cycle between;
  - mem_wdata follows wdata_b (e.g., 16'hBEEF) only while sel=1.
- req_b=1, wr_b=1, mem_done never asserted, TIMEOUT=8:
  - ack_b and err pulse in the 8th busy cycle;
  - mem_en drops next cycle;
  - last=B, so a subsequent simultaneous request grants A.
- mem_done asserted exactly in cycle TIMEOUT of BUSY_A -> ack_a=1, err=0.
- req_a dropped after 1 busy cycle -> transaction continues, ack_a still pulses on mem_done; mem_done pulses in IDLE produce no ack.
- rst pulsed during BUSY_B -> next cycle all outputs at reset values, no ack_b; the following simultaneous request grants A.
